// File: rtl/regfile_pingpong_wei.sv
// Ping-pong weight/flag register file: WR_NUM-word writes fill one bank while the other is exported.
// Optional macro REGPP_SETCNT_EN adds the set_cnt port counting completed fills.
module regfile_pingpong_wei #(
   parameter int DATA_WIDTH = 32,
   parameter int WR_NUM     = 2,
   parameter int RD_NUM     = 27,
   parameter int SLOT_NUM   = 28,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         datain_val,
   output logic                         datain_rdy,
   input  logic [DATA_WIDTH*WR_NUM-1:0] datain,
   output logic [RD_NUM-1:0]            dataout_val,
   input  logic [RD_NUM-1:0]            dataout_rls,
   output logic [DATA_WIDTH*RD_NUM-1:0] dataout,
   output logic                         bank_sel
`ifdef REGPP_SETCNT_EN
   ,output logic [15:0]                 set_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_FULL    = 2'd2,
      ST_ACTIVE  = 2'd3
   } bank_st_e;

   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(SLOT_NUM - WR_NUM);
   localparam logic [ADDR_WIDTH-1:0] WR_INC   = ADDR_WIDTH'(WR_NUM);

   bank_st_e              state_q [2];
   bank_st_e              state_d [2];
   logic                  wr_bank_q, wr_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [RD_NUM-1:0]     val_q, val_d;
   logic [RD_NUM-1:0]     val_rel_s;
   logic [DATA_WIDTH-1:0] mem_q [2][SLOT_NUM];
   logic [DATA_WIDTH-1:0] mem_d [2][SLOT_NUM];
   logic                  fire_s;
   logic                  we_s;
`ifdef REGPP_SETCNT_EN
   logic [15:0]           set_cnt_q, set_cnt_d;
`endif

   assign datain_rdy = (state_q[wr_bank_q] == ST_EMPTY) || (state_q[wr_bank_q] == ST_FILLING);
   assign fire_s     = datain_val && datain_rdy;
   assign we_s       = fire_s && !clear;
   assign val_rel_s  = val_q & ~dataout_rls;

   // Storage write path; clear deliberately does not touch the data
   always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < WR_NUM; k++) begin
         mem_d[wr_bank_q][wr_ptr_q + ADDR_WIDTH'(k)] = we_s ? datain[k*DATA_WIDTH +: DATA_WIDTH]
                                                            : mem_q[wr_bank_q][wr_ptr_q + ADDR_WIDTH'(k)];
      end
   end

   // Bank state, pointers and lane valids
   always_comb begin
      state_d   = state_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_ptr_d  = wr_ptr_q;
      val_d     = val_q;
`ifdef REGPP_SETCNT_EN
      set_cnt_d = set_cnt_q;
`endif
      if (clear) begin
         state_d[0] = ST_EMPTY;
         state_d[1] = ST_EMPTY;
         wr_bank_d  = 1'b0;
         rd_bank_d  = 1'b0;
         wr_ptr_d   = '0;
         val_d      = '0;
`ifdef REGPP_SETCNT_EN
         set_cnt_d  = 16'd0;
`endif
      end else begin
         // A write can only target rd_bank while that bank is EMPTY/FILLING, so no overlap here
         case (state_q[rd_bank_q])
            ST_FULL: begin
               state_d[rd_bank_q] = ST_ACTIVE;
               val_d              = '1;
            end
            ST_ACTIVE: begin
               val_d = val_rel_s;
               if ((val_q != '0) && (val_rel_s == '0)) begin
                  state_d[rd_bank_q] = ST_EMPTY;
                  rd_bank_d          = ~rd_bank_q;
               end else begin
                  state_d[rd_bank_q] = ST_ACTIVE;
               end
            end
            default: val_d = val_q;
         endcase
         if (fire_s) begin
            if (wr_ptr_q == LAST_PTR) begin
               wr_ptr_d           = '0;
               state_d[wr_bank_q] = ST_FULL;
               wr_bank_d          = ~wr_bank_q;
`ifdef REGPP_SETCNT_EN
               set_cnt_d          = set_cnt_q + 16'd1;
`endif
            end else begin
               wr_ptr_d           = wr_ptr_q + WR_INC;
               state_d[wr_bank_q] = ST_FILLING;
            end
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
      end
   end

   // State registers; reset also zeroes storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q[0] <= ST_EMPTY;
         state_q[1] <= ST_EMPTY;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_ptr_q   <= '0;
         val_q      <= '0;
         for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < SLOT_NUM; s++) begin
               mem_q[b][s] <= '0;
            end
         end
`ifdef REGPP_SETCNT_EN
         set_cnt_q  <= 16'd0;
`endif
      end else begin
         state_q   <= state_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_ptr_q  <= wr_ptr_d;
         val_q     <= val_d;
         mem_q     <= mem_d;
`ifdef REGPP_SETCNT_EN
         set_cnt_q <= set_cnt_d;
`endif
      end
   end

   for (genvar i = 0; i < RD_NUM; i++) begin : g_lane
      assign dataout[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_bank_q][i];
   end

   assign dataout_val = val_q;
   assign bank_sel    = rd_bank_q;
`ifdef REGPP_SETCNT_EN
   assign set_cnt     = set_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_pingpong_wei.sv
// Bench for regfile_pingpong_wei: directed scenarios plus random traffic against a set-queue model.
module tb_regfile_pingpong_wei;
   localparam int DW = 32;
   localparam int WN = 2;
   localparam int RN = 27;
   localparam int SN = 28;
   localparam int CW = RN*DW;

   typedef logic [SN*DW-1:0] set_t;

   logic              clk = 1'b0;
   logic              reset, clear, datain_val, datain_rdy, bank_sel;
   logic [WN*DW-1:0]  datain;
   logic [RN-1:0]     dataout_val, dataout_rls;
   logic [CW-1:0]     dataout;
`ifdef REGPP_SETCNT_EN
   logic [15:0]       set_cnt;
`endif

   regfile_pingpong_wei dut (
      .clk(clk), .reset(reset), .clear(clear),
      .datain_val(datain_val), .datain_rdy(datain_rdy), .datain(datain),
      .dataout_val(dataout_val), .dataout_rls(dataout_rls), .dataout(dataout),
      .bank_sel(bank_sel)
`ifdef REGPP_SETCNT_EN
      ,.set_cnt(set_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Model: completed sets wait in a queue; the head is exported once it goes live
   set_t          sets_q[$];
   set_t          fill_buf;
   int            fill_cnt;
   bit            head_live;
   logic [RN-1:0] m_mask;
   int            recycles;
   int            m_setcnt;
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sets_q.delete();
      fill_buf  = '0;
      fill_cnt  = 0;
      head_live = 0;
      m_mask    = '0;
      recycles  = 0;
      m_setcnt  = 0;
   endtask

   task automatic model_edge();
      bit rdy_m;
      int held;
      rdy_m = (sets_q.size() < 2);
      held  = sets_q.size();
      if (clear) begin
         model_reset();
      end else begin
         if (head_live) begin
            m_mask = m_mask & ~dataout_rls;
            if (m_mask == '0) begin
               void'(sets_q.pop_front());
               head_live = 0;
               recycles++;
            end
         end else if (held > 0) begin
            head_live = 1;
            m_mask    = '1;
         end
         if (datain_val && rdy_m) begin
            fill_buf[fill_cnt*DW +: WN*DW] = datain;
            fill_cnt += WN;
            if (fill_cnt == SN) begin
               sets_q.push_back(fill_buf);
               fill_cnt = 0;
               m_setcnt++;
            end
         end
      end
   endtask

   task automatic compare_outputs(input string tag);
      set_t head;
      check_eq({tag, "/rdy"}, CW'(datain_rdy), CW'(sets_q.size() < 2));
      check_eq({tag, "/val"}, CW'(dataout_val), head_live ? CW'(m_mask) : CW'(0));
      check_eq({tag, "/bank_sel"}, CW'(bank_sel), CW'(recycles % 2));
      if (head_live) begin
         head = sets_q[0];
         check_eq({tag, "/dataout"}, dataout, head[CW-1:0]);
      end
`ifdef REGPP_SETCNT_EN
      check_eq({tag, "/set_cnt"}, CW'(set_cnt), CW'(m_setcnt % 65536));
`endif
   endtask

   task automatic step(input string tag, input bit v, input logic [WN*DW-1:0] d,
                       input logic [RN-1:0] r, input bit c);
      datain_val  = v;
      datain      = d;
      dataout_rls = r;
      clear       = c;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_outputs(tag);
   endtask

   function automatic logic [WN*DW-1:0] pair(input int k);
      return {32'(2*k + 1), 32'(2*k)};
   endfunction

   initial begin
      logic [RN-1:0] r;
      reset = 1'b1; clear = 1'b0; datain_val = 1'b0; datain = '0; dataout_rls = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("rst/dataout", dataout, CW'(0));
      compare_outputs("rst");
      reset = 1'b0;

      for (int k = 0; k < 14; k++) step("fill0", 1'b1, pair(k), '0, 1'b0);
      step("act0", 1'b0, '0, '0, 1'b0);
      check_eq("act0/val_all", CW'(dataout_val), CW'(27'h7FFFFFF));
      check_eq("act0/lane5", CW'(dataout[5*DW +: DW]), CW'(5));
      check_eq("act0/lane26", CW'(dataout[26*DW +: DW]), CW'(26));

      for (int k = 0; k < 14; k++) step("fill1", 1'b1, {$urandom, $urandom}, '0, 1'b0);
      for (int k = 0; k < 3; k++) step("stall", 1'b1, {$urandom, $urandom}, '0, 1'b0);
      check_eq("stall/rdy0", CW'(datain_rdy), CW'(0));

      for (int g = 0; g < 13; g++) begin
         r = RN'(3) << (2*g);
         step("rls", 1'b0, '0, r, 1'b0);
      end
      step("rls_dup", 1'b0, '0, RN'(1) << 3, 1'b0);
      step("rls26", 1'b0, '0, (RN'(1) << 26) | RN'(1), 1'b0);
      check_eq("recycle/val0", CW'(dataout_val), CW'(0));
      check_eq("recycle/bank1", CW'(bank_sel), CW'(1));
      step("act1", 1'b0, '0, '0, 1'b0);
      check_eq("act1/val_all", CW'(dataout_val), CW'(27'h7FFFFFF));

      for (int k = 0; k < 5; k++) step("part", 1'b1, {$urandom, $urandom}, '0, 1'b0);
      step("clear", 1'b0, '0, '0, 1'b1);
      check_eq("clear/val0", CW'(dataout_val), CW'(0));
      for (int k = 0; k < 14; k++) step("refill", 1'b1, pair(k + 100), '0, 1'b0);
      step("refill_act", 1'b0, '0, '0, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < RN; i++) r[i] = ($urandom_range(0, 5) == 0);
         step("rand", $urandom_range(0, 3) != 0, {$urandom, $urandom}, r,
              $urandom_range(0, 399) == 0);
      end

      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      check_eq("rst2/dataout", dataout, CW'(0));
      compare_outputs("rst2");
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
